// File: rtl/eth_rx_frame_ctrl.sv
// eth_rx_frame_ctrl: writes GMII receive beats into a ring of 2^NBUF_LOG2 frame buffers and queues good frames for the host.
// Optional destination-address filter is built when RX_MAC_FILTER_EN is defined.
module eth_rx_frame_ctrl #(
    parameter int BUF_AW    = 11,
    parameter int NBUF_LOG2 = 2,
    parameter int MIN_LEN   = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  s_axis_tdata,
    input  logic                        s_axis_tvalid,
    input  logic                        s_axis_tlast,
    input  logic                        s_axis_tuser,
    input  logic                        rx_enable,
    output logic                        buf_we,
    output logic [NBUF_LOG2+BUF_AW-1:0] buf_waddr,
    output logic [7:0]                  buf_wdata,
    output logic                        rx_avail,
    output logic [NBUF_LOG2-1:0]        rx_head_idx,
    output logic [BUF_AW:0]             rx_len,
    input  logic                        rx_release,
    output logic [15:0]                 frames_ok,
    output logic [15:0]                 frames_drop,
    input  logic [47:0]                 mac_addr,
    input  logic                        promisc
);
    localparam int                   NBUF      = 2 ** NBUF_LOG2;
    localparam logic [BUF_AW:0]      BUF_SIZE  = {1'b1, {BUF_AW{1'b0}}};
    localparam logic [BUF_AW:0]      MIN_LEN_C = (BUF_AW+1)'(MIN_LEN);
    localparam logic [BUF_AW:0]      ONE_LEN   = (BUF_AW+1)'(1);
    localparam logic [BUF_AW:0]      FILT_LAST = (BUF_AW+1)'(5);
    localparam logic [NBUF_LOG2+1:0] NBUF_C    = (NBUF_LOG2+2)'(NBUF);

    typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DROP = 2'd2} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t                        state_r;
    logic [NBUF_LOG2-1:0]          wr_idx_r, rd_idx_r;
    logic [NBUF_LOG2:0]            count_r, count_nxt_s;
    logic [BUF_AW:0]               byte_cnt_r, end_len_s;
    logic [BUF_AW:0]               len_mem_r [NBUF];
    logic                          commit_now_r, commit_late_r, drop_counted_r;
    logic                          buf_we_r, rx_avail_r;
    logic [NBUF_LOG2+BUF_AW-1:0]   buf_waddr_r;
    logic [7:0]                    buf_wdata_r;
    logic [15:0]                   frames_ok_r, frames_drop_r;
    logic [NBUF_LOG2+1:0]          busy_s;
    logic                          full_s, release_s, good_s, filt_fail_s;

`ifdef RX_MAC_FILTER_EN
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        case (idx)
            3'd0:    return mac[47:40];
            3'd1:    return mac[39:32];
            3'd2:    return mac[31:24];
            3'd3:    return mac[23:16];
            3'd4:    return mac[15:8];
            3'd5:    return mac[7:0];
            default: return 8'h00;
        endcase
    endfunction

    logic uc_ok_r, bc_ok_r, hit_uc_s, hit_bc_s;

    // Destination compare against station and broadcast address, decided on byte 5
    always_comb begin
        hit_uc_s    = (s_axis_tdata == mac_byte(mac_addr, byte_cnt_r[2:0]));
        hit_bc_s    = (s_axis_tdata == 8'hFF);
        filt_fail_s = (state_r == RECV) && (byte_cnt_r == FILT_LAST) && !promisc &&
                      !(uc_ok_r && hit_uc_s) && !(bc_ok_r && hit_bc_s);
    end
`else
    logic unused_s;
    assign unused_s = ^{mac_addr, promisc};

    // No address filter in this build
    always_comb begin
        filt_fail_s = 1'b0;
    end
`endif

    // Occupancy counts commits still in flight so a back-to-back frame never reuses a busy slot
    always_comb begin
        busy_s    = (NBUF_LOG2+2)'(count_r) + (NBUF_LOG2+2)'(commit_now_r) + (NBUF_LOG2+2)'(commit_late_r);
        full_s    = (busy_s >= NBUF_C);
        release_s = rx_release && rx_avail_r;
        if (state_r == IDLE) begin
            end_len_s = ONE_LEN;
        end else begin
            end_len_s = byte_cnt_r + ONE_LEN;
        end
        good_s = !s_axis_tuser && (end_len_s >= MIN_LEN_C) && !filt_fail_s;
        case ({commit_late_r, release_s})
            2'b10:   count_nxt_s = count_r + (NBUF_LOG2+1)'(1);
            2'b01:   count_nxt_s = count_r - (NBUF_LOG2+1)'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Receive FSM: RAM write port, buffer lengths, write index and frame counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            wr_idx_r       <= {NBUF_LOG2{1'b0}};
            byte_cnt_r     <= {(BUF_AW+1){1'b0}};
            commit_now_r   <= 1'b0;
            drop_counted_r <= 1'b0;
            buf_we_r       <= 1'b0;
            buf_waddr_r    <= {(NBUF_LOG2+BUF_AW){1'b0}};
            buf_wdata_r    <= 8'h00;
            frames_ok_r    <= 16'h0000;
            frames_drop_r  <= 16'h0000;
            for (int i = 0; i < NBUF; i++) len_mem_r[i] <= {(BUF_AW+1){1'b0}};
`ifdef RX_MAC_FILTER_EN
            uc_ok_r        <= 1'b0;
            bc_ok_r        <= 1'b0;
`endif
        end else begin
            buf_we_r     <= 1'b0;
            commit_now_r <= 1'b0;
            if (s_axis_tvalid) begin
                case (state_r)
                    IDLE: begin
                        drop_counted_r <= 1'b0;
                        if (!rx_enable || full_s) begin
                            if (s_axis_tlast) frames_drop_r <= sat_inc(frames_drop_r);
                            else              state_r       <= DROP;
                        end else begin
                            buf_we_r    <= 1'b1;
                            buf_waddr_r <= {wr_idx_r, {BUF_AW{1'b0}}};
                            buf_wdata_r <= s_axis_tdata;
                            byte_cnt_r  <= ONE_LEN;
`ifdef RX_MAC_FILTER_EN
                            uc_ok_r     <= (s_axis_tdata == mac_addr[47:40]);
                            bc_ok_r     <= (s_axis_tdata == 8'hFF);
`endif
                            if (s_axis_tlast) begin
                                if (good_s) begin
                                    len_mem_r[wr_idx_r] <= end_len_s;
                                    wr_idx_r            <= wr_idx_r + 1'b1;
                                    frames_ok_r         <= sat_inc(frames_ok_r);
                                    commit_now_r        <= 1'b1;
                                end else begin
                                    frames_drop_r <= sat_inc(frames_drop_r);
                                end
                            end else begin
                                state_r <= RECV;
                            end
                        end
                    end
                    RECV: begin
                        if (byte_cnt_r == BUF_SIZE) begin
                            if (s_axis_tlast) begin
                                frames_drop_r <= sat_inc(frames_drop_r);
                                state_r       <= IDLE;
                            end else begin
                                state_r <= DROP;
                            end
                        end else begin
                            buf_we_r    <= 1'b1;
                            buf_waddr_r <= {wr_idx_r, byte_cnt_r[BUF_AW-1:0]};
                            buf_wdata_r <= s_axis_tdata;
                            byte_cnt_r  <= byte_cnt_r + ONE_LEN;
`ifdef RX_MAC_FILTER_EN
                            if (byte_cnt_r <= FILT_LAST) begin
                                uc_ok_r <= uc_ok_r && hit_uc_s;
                                bc_ok_r <= bc_ok_r && hit_bc_s;
                            end
`endif
                            if (s_axis_tlast) begin
                                if (good_s) begin
                                    len_mem_r[wr_idx_r] <= end_len_s;
                                    wr_idx_r            <= wr_idx_r + 1'b1;
                                    frames_ok_r         <= sat_inc(frames_ok_r);
                                    commit_now_r        <= 1'b1;
                                end else begin
                                    frames_drop_r <= sat_inc(frames_drop_r);
                                end
                                state_r <= IDLE;
                            end else if (filt_fail_s) begin
                                frames_drop_r  <= sat_inc(frames_drop_r);
                                drop_counted_r <= 1'b1;
                                state_r        <= DROP;
                            end
                        end
                    end
                    DROP: begin
                        if (s_axis_tlast) begin
                            if (!drop_counted_r) frames_drop_r <= sat_inc(frames_drop_r);
                            state_r <= IDLE;
                        end
                    end
                    default: state_r <= IDLE;
                endcase
            end
        end
    end

    // Host queue: a commit becomes visible one edge after its last RAM write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_late_r <= 1'b0;
            count_r       <= {(NBUF_LOG2+1){1'b0}};
            rd_idx_r      <= {NBUF_LOG2{1'b0}};
            rx_avail_r    <= 1'b0;
        end else begin
            commit_late_r <= commit_now_r;
            count_r       <= count_nxt_s;
            rx_avail_r    <= (count_nxt_s != {(NBUF_LOG2+1){1'b0}});
            if (release_s) rd_idx_r <= rd_idx_r + 1'b1;
        end
    end

    assign buf_we      = buf_we_r;
    assign buf_waddr   = buf_waddr_r;
    assign buf_wdata   = buf_wdata_r;
    assign rx_avail    = rx_avail_r;
    assign rx_head_idx = rd_idx_r;
    assign rx_len      = len_mem_r[rd_idx_r];
    assign frames_ok   = frames_ok_r;
    assign frames_drop = frames_drop_r;

endmodule
